io_input_conditioner: RTL and testbench

Synchronises, debounces and normalises the board switches (SW) and push-buttons (KEY) before they enter the memory-mapped input words of data memory. It produces the 14-bit `io_input_bus` that data memory samples every cycle into its SW and KEY words. It also produces a one-cycle press pulse per key for any consumer that needs edge events. Every bit is handled independently by an identical per-bit conditioning channel.

---
 rtl/io_input_conditioner.sv | 79 +++++++
 tb/tb_io_input_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: per-bit synchronise, debounce and polarity-normalise
// the board switches and push-buttons. Produces the active-high input bus
// for data memory and a one-cycle press pulse per key.
module io_input_conditioner #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SW-1:0]          sw_raw,
    input  logic [NUM_KEY-1:0]         key_raw,
    output logic [NUM_SW+NUM_KEY-1:0]  io_input_bus,
    output logic [NUM_KEY-1:0]         key_press
);

    localparam int NB = NUM_SW + NUM_KEY;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]            raw;
    logic [NB-1:0]            s1;
    logic [NB-1:0]            s2;
    logic [NB-1:0]            q;
    logic [NB-1:0]            adopt;
    logic [NB-1:0][CNT_W-1:0] cnt;

    // Keys are active-low at the pins; invert once so everything downstream is active-high.
    assign raw          = {~key_raw, sw_raw};
    assign io_input_bus = q;

    // A channel adopts when its synchronised level has differed from q for DEBOUNCE_CYCLES edges.
    always_comb begin
        adopt = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            adopt[b] = (s2[b] != q[b]) && (cnt[b] == CNT_MAX);
        end
    end

    // Two-flop synchroniser for every pin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-bit stability counter and stable level register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q   <= '0;
            cnt <= '0;
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (s2[b] == q[b]) begin
                    cnt[b] <= '0;
                end else if (adopt[b]) begin
                    q[b]   <= s2[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    // Press pulse: registered alongside q, so it is high exactly in the cycle the key bit first reads 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_press <= '0;
        end else begin
            key_press <= adopt[NB-1:NUM_SW] & s2[NB-1:NUM_SW];
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Testbench for io_input_conditioner: directed scenarios followed by random
// stimulus, all compared against a history-based reference model.
module tb_io_input_conditioner;

    localparam int NUM_SW  = 10;
    localparam int NUM_KEY = 4;
    localparam int DEB     = 4;
    localparam int NB      = NUM_SW + NUM_KEY;

    logic                clock;
    logic                reset;
    logic [NUM_SW-1:0]   sw_raw;
    logic [NUM_KEY-1:0]  key_raw;
    logic [NB-1:0]       io_input_bus;
    logic [NUM_KEY-1:0]  key_press;

    int n_vec;
    int n_err;

    // Model state: every raw sample taken at a rising edge since reset, plus
    // the expected outputs after the latest edge.
    logic [NB-1:0]      hist[$];
    logic [NB-1:0]      q_m;
    logic [NUM_KEY-1:0] kp_m;

    io_input_conditioner #(
        .NUM_SW          (NUM_SW),
        .NUM_KEY         (NUM_KEY),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .key_raw      (key_raw),
        .io_input_bus (io_input_bus),
        .key_press    (key_press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hist_bit(input int idx, input int b);
        if (idx < 0) return 1'b0;
        return hist[idx][b];
    endfunction

    // A bit takes a new level at an edge when the synchronised level (the raw
    // sample from two edges earlier) has disagreed with the output for the
    // last DEB edges in a row.
    task automatic model_edge(input logic [NUM_SW-1:0] sw, input logic [NUM_KEY-1:0] key);
        int  n;
        logic diff;
        hist.push_back({~key, sw});
        n    = hist.size();
        kp_m = '0;
        for (int b = 0; b < NB; b++) begin
            diff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist_bit(n - 3 - j, b) == q_m[b]) diff = 1'b0;
            end
            if (diff) begin
                q_m[b] = ~q_m[b];
                if (b >= NUM_SW && q_m[b]) kp_m[b - NUM_SW] = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        q_m  = '0;
        kp_m = '0;
    endtask

    // Apply one input vector, let one rising edge pass, then compare.
    task automatic step(input logic [NUM_SW-1:0] sw, input logic [NUM_KEY-1:0] key);
        sw_raw  = sw;
        key_raw = key;
        @(posedge clock);
        model_edge(sw, key);
        #1;
        check_eq("bus", 32'(io_input_bus), 32'(q_m));
        check_eq("key_press", 32'(key_press), 32'(kp_m));
    endtask

    task automatic hold(input logic [NUM_SW-1:0] sw, input logic [NUM_KEY-1:0] key, input int cycles);
        for (int i = 0; i < cycles; i++) step(sw, key);
    endtask

    // Asynchronous reset pulse landing between edges; outputs must clear at once.
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("reset_bus", 32'(io_input_bus), 32'(0));
        check_eq("reset_kp", 32'(key_press), 32'(0));
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        sw_raw  = '0;
        key_raw = 4'b1111;
        reset   = 1'b0;
        #3;
        pulse_reset();

        // Clean press and release on KEY0: rise and pulse on the 6th edge, fall with no pulse.
        hold(10'h000, 4'b1110, 5);
        check_eq("press_not_yet", 32'(io_input_bus[10]), 32'(0));
        step(10'h000, 4'b1110);
        check_eq("press_rise", 32'(io_input_bus[10]), 32'(1));
        check_eq("press_pulse", 32'(key_press), 32'(4'b0001));
        step(10'h000, 4'b1110);
        check_eq("press_pulse_end", 32'(key_press), 32'(0));
        hold(10'h000, 4'b1110, 3);
        hold(10'h000, 4'b1111, 5);
        check_eq("release_not_yet", 32'(io_input_bus[10]), 32'(1));
        step(10'h000, 4'b1111);
        check_eq("release_fall", 32'(io_input_bus[10]), 32'(0));
        check_eq("release_no_pulse", 32'(key_press), 32'(0));

        // Glitch rejection on SW2: 3 cycles rejected, 4 cycles accepted.
        hold(10'h004, 4'b1111, 3);
        hold(10'h000, 4'b1111, 8);
        check_eq("glitch3", 32'(io_input_bus[2]), 32'(0));
        hold(10'h004, 4'b1111, 4);
        hold(10'h000, 4'b1111, 2);
        check_eq("glitch4", 32'(io_input_bus[2]), 32'(1));
        hold(10'h000, 4'b1111, 8);

        // Chatter on KEY1 (pin values, one cycle each), then held pressed.
        step(10'h000, 4'b1111);
        step(10'h000, 4'b1111);
        step(10'h000, 4'b1101);
        step(10'h000, 4'b1111);
        step(10'h000, 4'b1101);
        step(10'h000, 4'b1101);
        step(10'h000, 4'b1111);
        hold(10'h000, 4'b1101, 8);
        check_eq("chatter_level", 32'(io_input_bus[11]), 32'(1));
        hold(10'h000, 4'b1111, 8);

        // All bits change together.
        hold(10'h3FF, 4'b0000, 5);
        step(10'h3FF, 4'b0000);
        check_eq("simul_bus", 32'(io_input_bus), 32'(14'h3FFF));
        check_eq("simul_pulse", 32'(key_press), 32'(4'b1111));
        hold(10'h000, 4'b1111, 8);
        check_eq("simul_clear", 32'(io_input_bus), 32'(0));

        // Reset in the middle of a KEY3 count; the held key is re-debounced from scratch.
        hold(10'h000, 4'b0111, 3);
        pulse_reset();
        hold(10'h000, 4'b0111, 5);
        check_eq("rst_mid_not_yet", 32'(io_input_bus[13]), 32'(0));
        step(10'h000, 4'b0111);
        check_eq("rst_mid_rise", 32'(io_input_bus[13]), 32'(1));
        check_eq("rst_mid_pulse", 32'(key_press), 32'(4'b1000));
        hold(10'h000, 4'b1111, 8);

        // Random stimulus: bits flip occasionally and are held for short random runs.
        begin
            logic [NUM_SW-1:0]  sw;
            logic [NUM_KEY-1:0] key;
            sw  = '0;
            key = '1;
            for (int r = 0; r < 400; r++) begin
                sw  = sw  ^ NUM_SW'($urandom & $urandom & $urandom);
                key = key ^ NUM_KEY'($urandom & $urandom);
                hold(sw, key, int'($urandom_range(1, 7)));
                if ($urandom_range(0, 49) == 0) pulse_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
